// File: rtl/vxe_vpu_cmd_sched.sv
// vxe_vpu_cmd_sched: in-order, single-issue command scheduler for the VPU ECUs.
// Commands are queued in a small FIFO, classified at pop time (register update
// vs. vector), strobed to the owning ECU for one cycle and then held on the
// shared command bus until that ECU reports done.
module vxe_vpu_cmd_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_vld,
   output logic        o_rdy,
   input  logic [4:0]  i_op,
   input  logic [2:0]  i_th,
   input  logic [47:0] i_pl,
   output logic [4:0]  o_cmd_op,
   output logic [2:0]  o_cmd_th,
   output logic [47:0] o_cmd_pl,
   output logic        o_regu_disp,
   input  logic        i_regu_done,
   output logic        o_vec_disp,
   input  logic        i_vec_done,
   output logic        o_busy,
   output logic        o_err
);

   // Control-unit opcodes owned by the register update ECU.
   localparam logic [4:0] CU_CMD_SETACC = 5'h01;
   localparam logic [4:0] CU_CMD_SETVL  = 5'h02;
   localparam logic [4:0] CU_CMD_SETEN  = 5'h03;
   localparam logic [4:0] CU_CMD_SETRS  = 5'h04;
   localparam logic [4:0] CU_CMD_SETRT  = 5'h05;
   localparam logic [4:0] CU_CMD_SETRD  = 5'h06;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 5 + 3 + 48;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DISP = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [1:0]    state;
   logic          cls_regu;
   logic          push;
   logic          pop;
   logic          fifo_nempty;
   logic          done_ok;
   logic          done_bad;
   logic [EW-1:0] head;

   function automatic logic is_regu(input logic [4:0] op);
      case (op)
         CU_CMD_SETACC, CU_CMD_SETVL, CU_CMD_SETEN,
         CU_CMD_SETRS, CU_CMD_SETRT, CU_CMD_SETRD: is_regu = 1'b1;
         default:                                  is_regu = 1'b0;
      endcase
   endfunction

   // Ready comes from the registered count only; a same-cycle pop does not
   // open a slot for a push while full.
   assign o_rdy       = (count != FULL_CNT);
   assign fifo_nempty = (count != '0);
   assign push        = i_vld & o_rdy;
   assign head        = mem[rd_ptr];

   // Done from the ECU that owns the in-flight command advances the FSM;
   // anything else is a protocol violation.
   assign done_ok  = (state == S_WAIT) & (cls_regu ? i_regu_done : i_vec_done);
   assign done_bad = (state == S_WAIT) ? (cls_regu ? i_vec_done : i_regu_done)
                                       : (i_regu_done | i_vec_done);

   // Pop only from IDLE, or from WAIT on the matching done.
   assign pop = fifo_nempty & ((state == S_IDLE) | done_ok);

   assign o_regu_disp = (state == S_DISP) &  cls_regu;
   assign o_vec_disp  = (state == S_DISP) & ~cls_regu;
   assign o_busy      = fifo_nempty | (state != S_IDLE);

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {i_op, i_th, i_pl};
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Dispatch FSM: latch head and class at pop, strobe once, hold until done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cls_regu <= 1'b0;
         o_cmd_op <= '0;
         o_cmd_th <= '0;
         o_cmd_pl <= '0;
      end else begin
         if (pop) begin
            {o_cmd_op, o_cmd_th, o_cmd_pl} <= head;
            cls_regu <= is_regu(head[EW-1 -: 5]);
         end
         case (state)
            S_IDLE:  if (pop) state <= S_DISP;
            S_DISP:  state <= S_WAIT;
            S_WAIT:  if (done_ok) state <= pop ? S_DISP : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)           o_err <= 1'b0;
      else if (done_bad) o_err <= 1'b1;
   end

endmodule

// File: tb/tb_vxe_vpu_cmd_sched.sv
// tb_vxe_vpu_cmd_sched: directed stimulus with a scoreboard. Accepted commands
// are queued with their expected class; a monitor pops and compares on every
// dispatch strobe and checks the command bus holds between dispatches.
module tb_vxe_vpu_cmd_sched;

   localparam logic [4:0] SETACC = 5'h01;
   localparam logic [4:0] SETVL  = 5'h02;
   localparam logic [4:0] SETEN  = 5'h03;
   localparam logic [4:0] SETRS  = 5'h04;
   localparam logic [4:0] SETRT  = 5'h05;
   localparam logic [4:0] SETRD  = 5'h06;
   localparam logic [4:0] VOPA   = 5'h10;
   localparam logic [4:0] VOPB   = 5'h1B;

   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  th;
      logic [47:0] pl;
      logic        regu;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_vld;
   logic [4:0]  i_op;
   logic [2:0]  i_th;
   logic [47:0] i_pl;
   logic        o_rdy;
   logic [4:0]  o_cmd_op;
   logic [2:0]  o_cmd_th;
   logic [47:0] o_cmd_pl;
   logic        o_regu_disp;
   logic        o_vec_disp;
   logic        o_busy;
   logic        o_err;
   logic        rsp_regu = 1'b0;
   logic        rsp_vec  = 1'b0;
   logic        inj_regu;
   logic        inj_vec;
   logic        regu_done;
   logic        vec_done;

   assign regu_done = rsp_regu | inj_regu;
   assign vec_done  = rsp_vec  | inj_vec;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          n_disp = 0;
   int          disp_cyc [64];
   logic        disp_regu [64];
   logic [47:0] disp_pl [64];
   exp_t        sbq [$];
   exp_t        last = '0;
   logic        prev_rdy = 1'b0;
   int          regu_lat = 1;
   int          vec_lat = 1;
   int          regu_cnt = 0;
   int          vec_cnt = 0;

   always #5 clk = ~clk;

   vxe_vpu_cmd_sched #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy),
      .i_op(i_op), .i_th(i_th), .i_pl(i_pl),
      .o_cmd_op(o_cmd_op), .o_cmd_th(o_cmd_th), .o_cmd_pl(o_cmd_pl),
      .o_regu_disp(o_regu_disp), .i_regu_done(regu_done),
      .o_vec_disp(o_vec_disp), .i_vec_done(vec_done),
      .o_busy(o_busy), .o_err(o_err)
   );

   function automatic logic exp_regu(input logic [4:0] op);
      exp_regu = (op == SETACC) || (op == SETVL) || (op == SETEN) ||
                 (op == SETRS)  || (op == SETRT) || (op == SETRD);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor + scoreboard + auto-responding ECUs, sampled 1ns after each edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      rsp_regu = 1'b0;
      rsp_vec  = 1'b0;
      if (rst) begin
         sbq.delete();
         last     = '0;
         regu_cnt = 0;
         vec_cnt  = 0;
      end else begin
         if (i_vld && prev_rdy) begin
            e.op = i_op; e.th = i_th; e.pl = i_pl; e.regu = exp_regu(i_op);
            sbq.push_back(e);
            n_acc++;
         end
         if (regu_cnt > 0) begin regu_cnt--; if (regu_cnt == 0) rsp_regu = 1'b1; end
         if (vec_cnt > 0)  begin vec_cnt--;  if (vec_cnt == 0)  rsp_vec  = 1'b1; end
         if (o_regu_disp || o_vec_disp) begin
            chk("single_strobe", 64'(o_regu_disp & o_vec_disp), 64'(0));
            if (sbq.size() == 0) begin
               chk("spurious_disp", 64'(1), 64'(0));
            end else begin
               e = sbq.pop_front();
               chk("disp_op", 64'(o_cmd_op), 64'(e.op));
               chk("disp_th", 64'(o_cmd_th), 64'(e.th));
               chk("disp_pl", 64'(o_cmd_pl), 64'(e.pl));
               chk("disp_class", 64'(o_regu_disp), 64'(e.regu));
            end
            last.op = o_cmd_op; last.th = o_cmd_th; last.pl = o_cmd_pl;
            if (n_disp < 64) begin
               disp_cyc[n_disp]  = cyc;
               disp_regu[n_disp] = o_regu_disp;
               disp_pl[n_disp]   = o_cmd_pl;
            end
            n_disp++;
            if (o_regu_disp && regu_lat > 0) regu_cnt = regu_lat;
            if (o_vec_disp  && vec_lat  > 0) vec_cnt  = vec_lat;
         end else begin
            chk("cmd_hold", {8'h0, o_cmd_op, o_cmd_th, o_cmd_pl},
                            {8'h0, last.op, last.th, last.pl});
         end
      end
      prev_rdy = o_rdy;
   end

   // Present one command and hold it until accepted; ac = accepting edge.
   task automatic push(input logic [4:0] op, input logic [2:0] th,
                       input logic [47:0] pl, output int ac);
      i_vld = 1'b1; i_op = op; i_th = th; i_pl = pl;
      for (int t = 0; t < 200 && !o_rdy; t++) @(negedge clk);
      if (!o_rdy) chk("push_timeout", 64'(o_rdy), 64'(1));
      @(negedge clk);
      ac = cyc;
      i_vld = 1'b0;
   endtask

   task automatic wait_idle(input int n);
      for (int t = 0; t < n && o_busy; t++) @(negedge clk);
      chk("idle_timeout", 64'(o_busy), 64'(0));
   endtask

   task automatic wait_disp(input int target);
      for (int t = 0; t < 100 && n_disp < target; t++) @(negedge clk);
      chk("disp_timeout", 64'(n_disp >= target), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int ac, ac6, dc, c0, a0;
      rst = 1'b1; i_vld = 1'b0; i_op = '0; i_th = '0; i_pl = '0;
      inj_regu = 1'b0; inj_vec = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy",  64'(o_rdy), 64'(1));
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_err",  64'(o_err), 64'(0));
      chk("rst_disp", 64'({o_regu_disp, o_vec_disp}), 64'(0));
      chk("rst_cmd",  {8'h0, o_cmd_op, o_cmd_th, o_cmd_pl}, 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single register-update command: strobe one cycle after pop, done next.
      regu_lat = 1; vec_lat = 1; c0 = n_disp;
      push(SETVL, 3'd2, 48'h10, ac);
      @(negedge clk);
      @(negedge clk);
      chk("t1_busy_wait", 64'(o_busy), 64'(1));
      @(negedge clk);
      chk("t1_busy_done", 64'(o_busy), 64'(0));
      chk("t1_cmd_op", 64'(o_cmd_op), 64'(SETVL));
      chk("t1_cmd_th", 64'(o_cmd_th), 64'(2));
      chk("t1_cmd_pl", 64'(o_cmd_pl), 64'(48'h10));
      repeat (3) @(negedge clk);
      chk("t1_strobes", 64'(n_disp - c0), 64'(1));
      chk("t1_disp_cyc", 64'(disp_cyc[c0]), 64'(ac + 1));
      chk("t1_disp_regu", 64'(disp_regu[c0]), 64'(1));

      // Mixed stream; vector ECU answers 5 cycles after its strobe, then the
      // following command is popped on the done edge and strobed right after.
      regu_lat = 1; vec_lat = 5; c0 = n_disp;
      push(SETRS, 3'd1, 48'hA1, ac);
      push(VOPA,  3'd3, 48'hB2, ac);
      push(SETRD, 3'd5, 48'hC3, ac);
      wait_idle(100);
      chk("t2_strobes", 64'(n_disp - c0), 64'(3));
      chk("t2_order0", 64'(disp_regu[c0]), 64'(1));
      chk("t2_order1", 64'(disp_regu[c0 + 1]), 64'(0));
      chk("t2_order2", 64'(disp_regu[c0 + 2]), 64'(1));
      chk("t2_vec_to_next", 64'(disp_cyc[c0 + 2] - disp_cyc[c0 + 1]), 64'(6));
      chk("t2_err", 64'(o_err), 64'(0));

      // Full FIFO: one command in flight plus four queued; a sixth must wait
      // for the first done.
      regu_lat = -1; vec_lat = -1; c0 = n_disp; a0 = n_acc;
      push(SETEN, 3'd0, 48'h100, ac);
      push(VOPA,  3'd1, 48'h101, ac);
      push(SETRT, 3'd2, 48'h102, ac);
      push(VOPB,  3'd3, 48'h103, ac);
      chk("t3_rdy_3q", 64'(o_rdy), 64'(1));
      push(SETACC, 3'd4, 48'h104, ac);
      chk("t3_rdy_full", 64'(o_rdy), 64'(0));
      chk("t3_acc5", 64'(n_acc - a0), 64'(5));
      chk("t3_inflight", 64'(n_disp - c0), 64'(1));
      dc = 0; ac6 = 0;
      fork
         push(VOPB, 3'd7, 48'h105, ac6);
         begin
            repeat (3) @(negedge clk);
            chk("t3_still_full", 64'(o_rdy), 64'(0));
            chk("t3_no_extra_acc", 64'(n_acc - a0), 64'(5));
            regu_lat = 1; vec_lat = 1;
            inj_regu = 1'b1; dc = cyc;
            @(negedge clk);
            inj_regu = 1'b0;
         end
      join
      chk("t3_acc6_after_done", 64'(ac6), 64'(dc + 2));
      wait_idle(200);
      chk("t3_acc6", 64'(n_acc - a0), 64'(6));
      chk("t3_disp6", 64'(n_disp - c0), 64'(6));
      chk("t3_sb_empty", 64'(sbq.size()), 64'(0));

      // Pointer wrap: 12 commands through a 4-entry FIFO, payload order kept.
      regu_lat = 1; vec_lat = 1; c0 = n_disp;
      for (int i = 0; i < 12; i++)
         push((i % 3 == 0) ? SETVL : VOPA, 3'(i), 48'(i), ac);
      wait_idle(200);
      chk("t4_disp12", 64'(n_disp - c0), 64'(12));
      for (int i = 0; i < 12; i++)
         chk("t4_pl_order", 64'(disp_pl[c0 + i]), 64'(i));

      // Wrong-class done while a SETACC waits: error set, FSM keeps waiting.
      regu_lat = -1; vec_lat = -1; c0 = n_disp;
      push(SETACC, 3'd4, 48'h5A, ac);
      wait_disp(c0 + 1);
      @(negedge clk);
      inj_vec = 1'b1;
      @(negedge clk);
      inj_vec = 1'b0;
      @(negedge clk);
      chk("t5_err_set", 64'(o_err), 64'(1));
      chk("t5_still_wait", 64'(o_busy), 64'(1));
      chk("t5_no_redisp", 64'(n_disp - c0), 64'(1));
      inj_regu = 1'b1;
      @(negedge clk);
      inj_regu = 1'b0;
      @(negedge clk);
      chk("t5_done_ok", 64'(o_busy), 64'(0));
      repeat (3) @(negedge clk);
      chk("t5_err_sticky", 64'(o_err), 64'(1));

      // Reset while one command waits and two are queued.
      c0 = n_disp;
      push(SETRS, 3'd1, 48'hD1, ac);
      push(VOPA,  3'd2, 48'hD2, ac);
      push(SETRD, 3'd3, 48'hD3, ac);
      chk("t6_pre_busy", 64'(o_busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_busy", 64'(o_busy), 64'(0));
      chk("t6_rdy", 64'(o_rdy), 64'(1));
      chk("t6_disp", 64'({o_regu_disp, o_vec_disp}), 64'(0));
      chk("t6_err", 64'(o_err), 64'(0));
      repeat (4) @(negedge clk);
      chk("t6_dropped", 64'(n_disp - c0), 64'(1));
      chk("t6_idle", 64'(o_busy), 64'(0));
      inj_regu = 1'b1;
      @(negedge clk);
      inj_regu = 1'b0;
      @(negedge clk);
      chk("t6_stale_done_err", 64'(o_err), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
